work_dispatcher: RTL and testbench

- Host-side front end of the hashing core array.
- Collects one 96-byte work unit from a byte stream: 32 bytes of midstate, then 64 bytes of header.
- Loads the work unit into the SHA block, enables solving, then waits for a golden-nonce flag or a cycle-budget timeout.
- Returns a 5-byte result over a byte transmit stream. It sits between the host link (UART/SPI byte layer) and sha_block.

---
 rtl/work_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_work_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/work_dispatcher.sv
// Host-side work dispatcher: gathers a 96-byte work unit, drives the SHA block
// through load and solve, then streams a 5-byte result back to the host.
module work_dispatcher #(
    parameter int unsigned LOAD_CYCLES      = 2,
    parameter logic [31:0] MAX_SOLVE_CYCLES = 32'd4294967295
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic         abort,
    output logic [255:0] midState,
    output logic [511:0] headData,
    output logic         loadState,
    output logic         solveEn,
    input  logic         flag,
    input  logic [31:0]  goldenNonce,
    output logic         busy
);

    typedef enum logic [1:0] {S_RECV, S_LOAD, S_SOLVE, S_REPORT} state_t;

    // A zero load length still holds loadState for one cycle.
    localparam logic [31:0] LOAD_LAST  = (LOAD_CYCLES > 0) ? 32'(LOAD_CYCLES - 1) : '0;
    localparam logic [31:0] SOLVE_LAST = MAX_SOLVE_CYCLES - 32'd1;

    state_t         state_q;
    logic [6:0]     byte_cnt_q;
    logic [31:0]    load_cnt_q;
    logic [31:0]    solve_cnt_q;
    logic [7:0]     status_q;
    logic [31:0]    nonce_q;
    logic [2:0]     tx_idx_q;
    logic [255:0]   midState_q;
    logic [511:0]   headData_q;
    logic           loadState_q;
    logic           solveEn_q;
    logic           tx_valid_q;
    logic [7:0]     tx_data_q;
    logic           busy_q;

    logic           rx_fire;
    logic           tx_fire;
    logic [4:0]     mid_sel;
    logic [6:0]     head_off;
    logic [5:0]     head_sel;
    logic [7:0]     next_byte;

    assign rx_ready  = !rst && (state_q == S_RECV);
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid_q && tx_ready;

    assign midState  = midState_q;
    assign headData  = headData_q;
    assign loadState = loadState_q;
    assign solveEn   = solveEn_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;

    // Byte k lands MSB-first: slot index counts down from the top of each field.
    always_comb begin
        mid_sel  = ~byte_cnt_q[4:0];
        head_off = byte_cnt_q - 7'd32;
        head_sel = ~head_off[5:0];
        unique case (tx_idx_q)
            3'd0:    next_byte = nonce_q[31:24];
            3'd1:    next_byte = nonce_q[23:16];
            3'd2:    next_byte = nonce_q[15:8];
            default: next_byte = nonce_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RECV;
            byte_cnt_q  <= '0;
            load_cnt_q  <= '0;
            solve_cnt_q <= '0;
            status_q    <= '0;
            nonce_q     <= '0;
            tx_idx_q    <= '0;
            midState_q  <= '0;
            headData_q  <= '0;
            loadState_q <= 1'b0;
            solveEn_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
        end else if (abort && state_q != S_RECV) begin
            state_q     <= S_RECV;
            loadState_q <= 1'b0;
            solveEn_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_RECV: begin
                    if (abort) begin
                        byte_cnt_q <= '0;
                    end else if (rx_fire) begin
                        if (byte_cnt_q < 7'd32)
                            midState_q[{mid_sel, 3'b000} +: 8] <= rx_data;
                        else
                            headData_q[{head_sel, 3'b000} +: 8] <= rx_data;
                        if (byte_cnt_q == 7'd95) begin
                            byte_cnt_q  <= '0;
                            load_cnt_q  <= '0;
                            loadState_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_LOAD;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 7'd1;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        loadState_q <= 1'b0;
                        solveEn_q   <= 1'b1;
                        solve_cnt_q <= '0;
                        state_q     <= S_SOLVE;
                    end else begin
                        load_cnt_q <= load_cnt_q + 32'd1;
                    end
                end
                S_SOLVE: begin
                    if (flag) begin
                        status_q   <= 8'h01;
                        nonce_q    <= goldenNonce;
                        tx_data_q  <= 8'h01;
                        tx_valid_q <= 1'b1;
                        tx_idx_q   <= '0;
                        solveEn_q  <= 1'b0;
                        state_q    <= S_REPORT;
                    end else if (solve_cnt_q == SOLVE_LAST) begin
                        status_q   <= 8'h00;
                        nonce_q    <= 32'hFFFF_FFFF;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b1;
                        tx_idx_q   <= '0;
                        solveEn_q  <= 1'b0;
                        state_q    <= S_REPORT;
                    end else begin
                        solve_cnt_q <= solve_cnt_q + 32'd1;
                    end
                end
                S_REPORT: begin
                    if (tx_fire) begin
                        if (tx_idx_q == 3'd4) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_RECV;
                        end else begin
                            tx_data_q <= next_byte;
                            tx_idx_q  <= tx_idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized job-level bench for work_dispatcher against a result/field reference model.
module tb_work_dispatcher;

    localparam int unsigned LC = 2;
    localparam logic [31:0] MS = 32'd16;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         abort;
    logic [255:0] midState;
    logic [511:0] headData;
    logic         loadState;
    logic         solveEn;
    logic         flag;
    logic [31:0]  goldenNonce;
    logic         busy;

    int unsigned  n_checks;
    int unsigned  n_errors;
    logic [7:0]   job [96];

    work_dispatcher #(.LOAD_CYCLES(LC), .MAX_SOLVE_CYCLES(MS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .abort(abort),
        .midState(midState), .headData(headData), .loadState(loadState), .solveEn(solveEn),
        .flag(flag), .goldenNonce(goldenNonce), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 96; k++) job[k] = 8'($urandom);
    endtask

    // Sends the first n bytes of job[] with random idle gaps; flag noise is ignored in RECV.
    task automatic send_job(input int n);
        int idx;
        idx = 0;
        while (idx < n) begin
            rx_valid    = ($urandom % 4) != 0;
            rx_data     = rx_valid ? job[idx] : 8'($urandom);
            flag        = 1'($urandom);
            goldenNonce = $urandom;
            check("rx_ready_recv", 512'(rx_ready), 512'd1);
            tick();
            if (rx_valid) idx++;
        end
        rx_valid = 1'b0;
        flag     = 1'b0;
    endtask

    task automatic do_abort(input logic [255:0] em, input logic [511:0] eh);
        abort    = 1'b1;
        flag     = 1'b0;
        tx_ready = 1'($urandom);
        tick();
        abort = 1'b0;
        check("abort_loadState", 512'(loadState), 512'd0);
        check("abort_solveEn", 512'(solveEn), 512'd0);
        check("abort_busy", 512'(busy), 512'd0);
        check("abort_rx_ready", 512'(rx_ready), 512'd1);
        check("abort_midState", 512'(midState), 512'(em));
        check("abort_headData", headData, eh);
        for (int c = 0; c < 3; c++) begin
            check("abort_tx_valid", 512'(tx_valid), 512'd0);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rx_ready_comb", 512'(rx_ready), 512'd0);
        tick();
        check("rst_tx_valid", 512'(tx_valid), 512'd0);
        check("rst_tx_data", 512'(tx_data), 512'd0);
        check("rst_midState", 512'(midState), 512'd0);
        check("rst_headData", headData, 512'd0);
        check("rst_loadState", 512'(loadState), 512'd0);
        check("rst_solveEn", 512'(solveEn), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_rx_ready", 512'(rx_ready), 512'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rx_ready", 512'(rx_ready), 512'd1);
    endtask

    // ab_sel: 0 none, 1 abort in LOAD, 2 abort in SOLVE, 3 abort in REPORT, 4 reset in REPORT.
    task automatic run_job(input int flag_at, input logic [31:0] nonce, input int txmode,
                           input int ab_sel, input int ab_cyc);
        logic [255:0] em;
        logic [511:0] eh;
        logic [7:0]   eb [5];
        logic [7:0]   status;
        logic [31:0]  rn;
        int           term;
        int           idx;
        int           cyc;
        em = '0;
        eh = '0;
        for (int k = 0; k < 32; k++) em = {em[247:0], job[k]};
        for (int k = 32; k < 96; k++) eh = {eh[503:0], job[k]};
        if (flag_at >= 0 && flag_at < int'(MS)) begin
            term = flag_at; status = 8'h01; rn = nonce;
        end else begin
            term = int'(MS) - 1; status = 8'h00; rn = 32'hFFFF_FFFF;
        end
        eb[0] = status; eb[1] = rn[31:24]; eb[2] = rn[23:16]; eb[3] = rn[15:8]; eb[4] = rn[7:0];

        send_job(96);
        for (int c = 0; c < int'(LC); c++) begin
            if (ab_sel == 1 && c == ab_cyc % int'(LC)) begin
                do_abort(em, eh);
                return;
            end
            flag = 1'($urandom);
            check("load_loadState", 512'(loadState), 512'd1);
            check("load_solveEn", 512'(solveEn), 512'd0);
            check("load_busy", 512'(busy), 512'd1);
            check("load_rx_ready", 512'(rx_ready), 512'd0);
            tick();
        end
        for (int s = 0; s <= term; s++) begin
            if (ab_sel == 2 && s == ab_cyc % (term + 1)) begin
                do_abort(em, eh);
                return;
            end
            flag        = (s == flag_at);
            goldenNonce = (s == flag_at) ? nonce : $urandom;
            check("solve_solveEn", 512'(solveEn), 512'd1);
            check("solve_loadState", 512'(loadState), 512'd0);
            check("solve_tx_valid", 512'(tx_valid), 512'd0);
            tick();
        end
        flag = 1'b0;
        check("job_midState", 512'(midState), 512'(em));
        check("job_headData", headData, eh);
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 200) begin
            if (ab_sel == 3 && cyc == ab_cyc % 8) begin
                do_abort(em, eh);
                return;
            end
            if (ab_sel == 4 && cyc == ab_cyc % 8) begin
                do_reset();
                return;
            end
            case (txmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2) == 0;
                default: tx_ready = 1'($urandom);
            endcase
            check("rep_tx_valid", 512'(tx_valid), 512'd1);
            check("rep_tx_data", 512'(tx_data), 512'(eb[idx]));
            check("rep_solveEn", 512'(solveEn), 512'd0);
            check("rep_busy", 512'(busy), 512'd1);
            if (tx_ready) idx++;
            tick();
            cyc++;
        end
        tx_ready = 1'b0;
        check("rep_bytes_delivered", 512'(idx), 512'd5);
        check("done_tx_valid", 512'(tx_valid), 512'd0);
        check("done_rx_ready", 512'(rx_ready), 512'd1);
        check("done_busy", 512'(busy), 512'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        rx_data     = '0;
        rx_valid    = 1'b0;
        tx_ready    = 1'b0;
        abort       = 1'b0;
        flag        = 1'b0;
        goldenNonce = '0;
        repeat (3) tick();
        check("reset_rx_ready", 512'(rx_ready), 512'd0);
        check("reset_busy", 512'(busy), 512'd0);
        check("reset_tx_valid", 512'(tx_valid), 512'd0);
        check("reset_tx_data", 512'(tx_data), 512'd0);
        check("reset_loadState", 512'(loadState), 512'd0);
        check("reset_solveEn", 512'(solveEn), 512'd0);
        check("reset_midState", 512'(midState), 512'd0);
        check("reset_headData", headData, 512'd0);
        rst = 1'b0;
        #1;
        check("reset_release_rx_ready", 512'(rx_ready), 512'd1);

        for (int k = 0; k < 96; k++) job[k] = 8'(k);
        run_job(10, 32'hDEAD_BEEF, 0, 0, 0);
        fill_random();
        run_job(-1, 32'h0, 0, 0, 0);
        fill_random();
        run_job(15, 32'h1234_5678, 0, 0, 0);
        fill_random();
        run_job(3, $urandom, 1, 0, 0);

        fill_random();
        send_job(41);
        abort    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        abort    = 1'b0;
        rx_valid = 1'b0;
        check("partial_abort_busy", 512'(busy), 512'd0);
        for (int k = 0; k < 96; k++) job[k] = 8'hA0;
        run_job(5, $urandom, 2, 0, 0);

        fill_random(); run_job(12, $urandom, 0, 2, 7);
        fill_random(); run_job(4, $urandom, 0, 1, 1);
        fill_random(); run_job(2, $urandom, 2, 3, 3);
        fill_random(); run_job(-1, 32'h0, 0, 4, 2);
        fill_random(); run_job(0, $urandom, 0, 0, 0);

        for (int j = 0; j < 20; j++) begin
            fill_random();
            run_job(int'($urandom_range(0, 20)) - 1, $urandom, int'($urandom_range(0, 2)),
                    (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0,
                    int'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
